// File: rtl/dkstr_pkg.sv
// Shared definitions for the path walker: direction codes, cost width/unreached marker and FSM states.
package dkstr_pkg;

    localparam int COST_W = 12;
    localparam logic [COST_W-1:0] COST_INF = '1;

    // Bit 3 flags "has predecessor"; bits 2:0 name the predecessor clockwise from north.
    typedef enum logic [3:0] {
        DIR_NONE = 4'b0000,
        DIR_N    = 4'b1000,
        DIR_NE   = 4'b1001,
        DIR_E    = 4'b1010,
        DIR_SE   = 4'b1011,
        DIR_S    = 4'b1100,
        DIR_SW   = 4'b1101,
        DIR_W    = 4'b1110,
        DIR_NW   = 4'b1111
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/path_walker_if.sv
// Grid-read and step-output handshakes of the path walker; master is the walker side.
interface path_walker_if #(
    parameter int CB        = 4,
    parameter int COST_SIZE = 12
);
    logic                 rd_req;
    logic [CB-1:0]        rd_x;
    logic [CB-1:0]        rd_y;
    logic                 rd_ack;
    logic [3:0]           rd_dir;
    logic [COST_SIZE-1:0] rd_cost;

    logic                 step_valid;
    logic                 step_ready;
    logic [CB-1:0]        step_x;
    logic [CB-1:0]        step_y;
    logic [3:0]           step_dir;
    logic [COST_SIZE-1:0] step_cost;
    logic                 step_last;

    modport master (
        output rd_req, rd_x, rd_y,
        input  rd_ack, rd_dir, rd_cost,
        output step_valid, step_x, step_y, step_dir, step_cost, step_last,
        input  step_ready
    );

    modport slave (
        input  rd_req, rd_x, rd_y,
        output rd_ack, rd_dir, rd_cost,
        input  step_valid, step_x, step_y, step_dir, step_cost, step_last,
        output step_ready
    );
endinterface

// File: rtl/path_walker_dir_step.sv
// Combinational predecessor lookup: applies a direction code to (x,y) and flags results off the grid.
module dir_step
    import dkstr_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int CB     = 4
) (
    input  logic [CB-1:0] x,
    input  logic [CB-1:0] y,
    input  logic [3:0]    dir,
    output logic [CB-1:0] nx,
    output logic [CB-1:0] ny,
    output logic          oob
);
    localparam logic signed [CB:0] P1   = (CB+1)'(1);
    localparam logic signed [CB:0] M1   = '1;
    localparam logic signed [CB:0] XMAX = (CB+1)'(GRID_W - 1);
    localparam logic signed [CB:0] YMAX = (CB+1)'(GRID_H - 1);

    logic signed [CB:0] dx, dy, sx, sy;

    // NOTE: every combinational output gets a default first so no path through the case infers a latch.
    always_comb begin
        dx = '0;
        dy = '0;
        case (dir)
            DIR_N:   dy = M1;
            DIR_NE:  begin dx = P1; dy = M1; end
            DIR_E:   dx = P1;
            DIR_SE:  begin dx = P1; dy = P1; end
            DIR_S:   dy = P1;
            DIR_SW:  begin dx = M1; dy = P1; end
            DIR_W:   dx = M1;
            DIR_NW:  begin dx = M1; dy = M1; end
            default: ;
        endcase
    end

    // One spare bit keeps x-1 at x=0 visible as a negative value.
    assign sx  = $signed({1'b0, x}) + dx;
    assign sy  = $signed({1'b0, y}) + dy;
    assign nx  = sx[CB-1:0];
    assign ny  = sy[CB-1:0];
    assign oob = sx[CB] | sy[CB] | (sx > XMAX) | (sy > YMAX);

endmodule

// File: rtl/path_walker.sv
// Walks a shortest-path tree from a destination back to its source, emitting one step per node.
// Optional feature: define PATH_WALKER_STEP_LIMIT_EN to abort walks longer than MAX_STEPS steps.
module path_walker
    import dkstr_pkg::*;
#(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 16,
    parameter int CB        = 4,
    parameter int COST_SIZE = COST_W,
    parameter int MAX_STEPS = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CB-1:0] start_x,
    input  logic [CB-1:0] start_y,
    output logic          busy,
    path_walker_if.master bus,
    output logic          done,
    output logic          err
);
    if ((2 ** CB) < GRID_W || (2 ** CB) < GRID_H || MAX_STEPS < 1) begin : g_cfg_check
        $error("path_walker: CB too narrow for the grid or MAX_STEPS < 1");
    end

    state_e        state, state_d;
    logic          err_d;
    logic [CB-1:0] cur_x, cur_y;
    logic [CB-1:0] nx, ny;
    logic          oob;
    logic          rd_hs, step_hs, cost_inf, limit_hit, advance;

    dir_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .CB     (CB)
    ) u_dir_step (
        .x   (bus.step_x),
        .y   (bus.step_y),
        .dir (bus.step_dir),
        .nx  (nx),
        .ny  (ny),
        .oob (oob)
    );

    assign rd_hs    = (state == ST_READ) && bus.rd_ack;
    assign step_hs  = (state == ST_EMIT) && bus.step_ready;
    assign cost_inf = &bus.rd_cost;
    assign advance  = step_hs && !bus.step_last && !oob && !limit_hit;

    always_comb begin
        state_d = state;
        err_d   = 1'b0;
        case (state)
            ST_IDLE: if (start) state_d = ST_READ;
            ST_READ: begin
                if (bus.rd_ack) begin
                    state_d = cost_inf ? ST_FIN : ST_EMIT;
                    err_d   = cost_inf;
                end
            end
            ST_EMIT: begin
                if (bus.step_ready) begin
                    if (bus.step_last) begin
                        state_d = ST_FIN;
                    end else if (oob || limit_hit) begin
                        state_d = ST_FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state and every registered output use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            bus.rd_req     <= 1'b0;
            bus.step_valid <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_d;
            busy           <= (state_d != ST_IDLE);
            bus.rd_req     <= (state_d == ST_READ);
            bus.step_valid <= (state_d == ST_EMIT);
            done           <= (state_d == ST_FIN);
            err            <= err_d;
        end
    end

    // The captured node record doubles as the step output and as the input of the next-coordinate lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x         <= '0;
            cur_y         <= '0;
            bus.step_x    <= '0;
            bus.step_y    <= '0;
            bus.step_dir  <= '0;
            bus.step_cost <= '0;
            bus.step_last <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                cur_x <= start_x;
                cur_y <= start_y;
            end else if (advance) begin
                cur_x <= nx;
                cur_y <= ny;
            end
            if (rd_hs) begin
                bus.step_x    <= cur_x;
                bus.step_y    <= cur_y;
                bus.step_dir  <= bus.rd_dir;
                bus.step_cost <= bus.rd_cost;
                bus.step_last <= ~bus.rd_dir[3];
            end
        end
    end

    assign bus.rd_x = cur_x;
    assign bus.rd_y = cur_y;

`ifdef PATH_WALKER_STEP_LIMIT_EN
    localparam int CNT_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    logic [CNT_W-1:0] step_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            step_cnt <= '0;
        end else if (advance) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    assign limit_hit = (step_cnt == CNT_W'(MAX_STEPS - 1));
`else
    assign limit_hit = 1'b0;
`endif

endmodule

// File: tb/tb_path_walker.sv
// Directed bench for path_walker: a grid responder plus a scoreboard of expected steps and end status.
module tb_path_walker;

`ifdef PATH_WALKER_STEP_LIMIT_EN
    localparam int TB_MAX_STEPS = 4;
`else
    localparam int TB_MAX_STEPS = 256;
`endif

    typedef struct packed {
        logic [3:0]  x;
        logic [3:0]  y;
        logic [3:0]  dir;
        logic [11:0] cost;
        logic        last;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] start_x, start_y;
    logic       busy, done, err;

    path_walker_if #(.CB(4), .COST_SIZE(12)) bus ();

    path_walker #(
        .GRID_W    (16),
        .GRID_H    (16),
        .CB        (4),
        .COST_SIZE (12),
        .MAX_STEPS (TB_MAX_STEPS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .start_x (start_x),
        .start_y (start_y),
        .busy    (busy),
        .bus     (bus),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  g_dir  [16][16];
    logic [11:0] g_cost [16][16];
    step_t       exp_q[$];
    logic        exp_err_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_grid();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) begin
                g_dir[i][j]  = 4'b0000;
                g_cost[i][j] = 12'h020;
            end
    endtask

    task automatic set_node(input int x, input int y, input logic [3:0] dir, input logic [11:0] cost);
        g_dir[x][y]  = dir;
        g_cost[x][y] = cost;
    endtask

    task automatic push_step(input int x, input int y, input logic last);
        step_t s;
        s.x    = 4'(x);
        s.y    = 4'(y);
        s.dir  = g_dir[x][y];
        s.cost = g_cost[x][y];
        s.last = last;
        exp_q.push_back(s);
    endtask

    function automatic step_t cur_step();
        step_t s;
        s.x    = bus.step_x;
        s.y    = bus.step_y;
        s.dir  = bus.step_dir;
        s.cost = bus.step_cost;
        s.last = bus.step_last;
        return s;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_req"}, bus.rd_req, 0);
        check({tag, "_step_valid"}, bus.step_valid, 0);
        check({tag, "_step_last"}, bus.step_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_rd_xy"}, {bus.rd_x, bus.rd_y}, 0);
        check({tag, "_step_data"}, {bus.step_x, bus.step_y, bus.step_dir, bus.step_cost}, 0);
    endtask

    // Called at a negedge; returns at a negedge. Services reads from the grid, checks each new step
    // against the scoreboard, optionally holds step_ready low on the first step, optionally stops
    // after a number of accepted steps without waiting for done.
    task automatic run_walk(input int sx, input int sy, input int bp_cycles, input int abort_after);
        step_t snap, got, want;
        bit    seen = 0, ack_prev = 0, hs_prev = 0, finished = 0, aborted = 0;
        int    bp = bp_cycles;
        int    n_steps = 0;

        start = 1'b1; start_x = 4'(sx); start_y = 4'(sy);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            if (ack_prev) check("ack_to_step_valid", bus.step_valid, 1);
            if (hs_prev) begin
                check("hs_to_rd_req_or_done", bus.rd_req | done, 1);
                seen = 0;
            end
            ack_prev = 0;
            hs_prev  = 0;

            if (done) begin
                start          = 1'b0;
                bus.rd_ack     = 1'b0;
                bus.step_ready = 1'b0;
                check("done_err", err, exp_err_q.size() > 0 ? exp_err_q.pop_front() : 1'bx);
                check("steps_left_at_done", exp_q.size(), 0);
                finished = 1;
                @(negedge clk);
                check("done_one_cycle", done, 0);
                check("idle_after_fin", busy, 0);
            end else begin
                // Random start pulses while busy must not disturb the walk.
                start   = 1'($urandom_range(0, 1));
                start_x = 4'($urandom_range(0, 15));
                start_y = 4'($urandom_range(0, 15));
                if (bus.rd_req) begin
                    bus.rd_ack  = 1'b1;
                    bus.rd_dir  = g_dir[bus.rd_x][bus.rd_y];
                    bus.rd_cost = g_cost[bus.rd_x][bus.rd_y];
                    ack_prev    = (bus.rd_cost != 12'hFFF);
                end else begin
                    bus.rd_ack  = 1'($urandom_range(0, 1));
                    bus.rd_dir  = 4'($urandom_range(0, 15));
                    bus.rd_cost = 12'($urandom_range(0, 4095));
                end
                if (bus.step_valid) begin
                    got = cur_step();
                    if (!seen) begin
                        seen = 1;
                        snap = got;
                        n_steps++;
                        check("step_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            want = exp_q.pop_front();
                            check("step_record", got, want);
                        end
                    end else begin
                        check("step_stable", got, snap);
                    end
                    if (bp > 0) begin
                        check("bp_no_rd_req", bus.rd_req, 0);
                        bp--;
                        bus.step_ready = 1'b0;
                    end else begin
                        bus.step_ready = 1'b1;
                        hs_prev = 1;
                    end
                end else begin
                    bus.step_ready = 1'($urandom_range(0, 1));
                end
                if (abort_after != 0 && n_steps == abort_after && hs_prev) begin
                    finished = 1;
                    aborted  = 1;
                end
                @(negedge clk);
            end
        end
        check("walk_finished_in_budget", finished, 1);
        start          = 1'b0;
        bus.rd_ack     = 1'b0;
        bus.step_ready = 1'b0;
        if (aborted) begin
            check("abort_still_busy", busy, 1);
            check("abort_no_done", done, 0);
            check("abort_next_read", bus.rd_req, 1);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        start_x        = '0;
        start_y        = '0;
        bus.rd_ack     = 1'b0;
        bus.rd_dir     = '0;
        bus.rd_cost    = '0;
        bus.step_ready = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_not_busy", busy, 0);

        // Straight walk south toward the source.
        clear_grid();
        set_node(3, 0, 4'b1100, 12'h00A);
        set_node(3, 1, 4'b1100, 12'h005);
        set_node(3, 2, 4'b0000, 12'h000);
        push_step(3, 0, 0); push_step(3, 1, 0); push_step(3, 2, 1);
        exp_err_q.push_back(1'b0);
        run_walk(3, 0, 0, 0);

        // Diagonal walk north-west down to the origin.
        clear_grid();
        set_node(2, 2, 4'b1111, 12'h00E);
        set_node(1, 1, 4'b1111, 12'h007);
        set_node(0, 0, 4'b0000, 12'h000);
        push_step(2, 2, 0); push_step(1, 1, 0); push_step(0, 0, 1);
        exp_err_q.push_back(1'b0);
        run_walk(2, 2, 0, 0);

        // Unreached start node: no step, error.
        clear_grid();
        set_node(7, 9, 4'b1000, 12'hFFF);
        exp_err_q.push_back(1'b1);
        run_walk(7, 9, 0, 0);

        // West off the left edge with 4 cycles of backpressure on the only step.
        clear_grid();
        set_node(0, 5, 4'b1110, 12'h003);
        push_step(0, 5, 0);
        exp_err_q.push_back(1'b1);
        run_walk(0, 5, 4, 0);

        // East off the right edge.
        clear_grid();
        set_node(15, 4, 4'b1010, 12'h011);
        push_step(15, 4, 0);
        exp_err_q.push_back(1'b1);
        run_walk(15, 4, 0, 0);

        // Two-node cycle (1,1) E <-> (2,1) W.
        clear_grid();
        set_node(1, 1, 4'b1010, 12'h009);
        set_node(2, 1, 4'b1110, 12'h008);
`ifdef PATH_WALKER_STEP_LIMIT_EN
        push_step(1, 1, 0); push_step(2, 1, 0); push_step(1, 1, 0); push_step(2, 1, 0);
        exp_err_q.push_back(1'b1);
        run_walk(1, 1, 0, 0);
`else
        for (int k = 0; k < 3; k++) begin
            push_step(1, 1, 0);
            push_step(2, 1, 0);
        end
        run_walk(1, 1, 0, 6);
        check("cycle_steps_consumed", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("cycle_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // Reset in READ with an ack pending, then a normal walk.
        clear_grid();
        set_node(3, 0, 4'b1100, 12'h00A);
        set_node(3, 1, 4'b1100, 12'h005);
        set_node(3, 2, 4'b0000, 12'h000);
        start = 1'b1; start_x = 4'd3; start_y = 4'd0;
        @(negedge clk);
        start = 1'b0;
        begin
            bit got_req = 0;
            for (int c = 0; c < 20 && !got_req; c++) begin
                if (bus.rd_req) got_req = 1;
                else @(negedge clk);
            end
            check("mid_walk_rd_req", got_req, 1);
        end
        bus.rd_ack  = 1'b1;
        bus.rd_dir  = 4'b1100;
        bus.rd_cost = 12'h00A;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        check("reset_no_done", done, 0);
        bus.rd_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        push_step(3, 0, 0); push_step(3, 1, 0); push_step(3, 2, 1);
        exp_err_q.push_back(1'b0);
        run_walk(3, 0, 0, 0);

        check("err_queue_drained", exp_err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/path_walker.md
PATH_WALKER -- requirements
Module: path_walker

Interface
REQ-001 Parameters SHALL be (name, default, meaning): GRID_W, 16, grid columns.
REQ-002 GRID_H, 16, grid rows.
REQ-003 CB, 4, coordinate width in bits; it SHALL satisfy 2^CB >= max(GRID_W, GRID_H).
REQ-004 COST_SIZE, 12, path-cost width in bits; all-ones SHALL mean unreached.
REQ-005 MAX_STEPS, 256, maximum number of steps emitted per walk.
REQ-006 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a walk; sampled only in IDLE.
- start_x, start_y  in  CB  destination node where the walk begins.
- busy  out  1  high in every state except IDLE.
- rd_req  out  1  grid read request.
- rd_x, rd_y  out  CB  address of the node being read.
- rd_ack  in  1  read response valid.
- rd_dir  in  4  node direction field.
- rd_cost  in  COST_SIZE  node cost.
- step_valid  out  1  emitted step is valid.
- step_ready  in  1  consumer accepts the step.
- step_x, step_y  out  CB  coordinates of the emitted step.
- step_dir  out  4  direction field of the emitted step.
- step_cost  out  COST_SIZE  cost of the emitted step.
- step_last  out  1  emitted step is the source node.
- done  out  1  one-cycle pulse at the end of a walk.
- err  out  1  valid with done; the walk aborted.

Function
REQ-007 The direction field SHALL decode as follows: rd_dir[3]=0 means no predecessor (source node); otherwise rd_dir[2:0] selects the predecessor as 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.
REQ-008 Direction offsets SHALL be: N is y-1, S is y+1, E is x+1, W is x-1; diagonals combine the two; arithmetic is signed with CB+1 bits.
REQ-009 The FSM SHALL have four states: IDLE, READ, EMIT and FIN.
REQ-010 IDLE: when start=1, the block SHALL latch start_x and start_y, clear the step counter and move to READ on the next edge.
REQ-011 READ: rd_req SHALL be 1, with rd_x and rd_y held stable, until rd_ack; on the ack cycle the block SHALL capture rd_dir and rd_cost.
REQ-012 READ ack with rd_cost all-ones: the block SHALL move to FIN with err=1 and emit no step.
REQ-013 READ ack otherwise: the block SHALL move to EMIT.
REQ-014 EMIT: step_valid SHALL be 1 and every step_* output SHALL stay stable until step_ready; step_last SHALL equal ~captured_dir[3].
REQ-015 EMIT handshake with step_last=1: the block SHALL move to FIN with err=0.
REQ-016 EMIT handshake with step_last=0: the block SHALL compute the next coordinates.
- Result outside [0,GRID_W-1] x [0,GRID_H-1]: the block SHALL move to FIN with err=1.
- Otherwise: the block SHALL update the coordinates, increment the step counter and move to READ.
REQ-017 FIN: done SHALL be 1 for exactly one cycle; err SHALL be valid in that cycle; the next state SHALL be IDLE.
REQ-018 Latency from the rd_ack cycle to step_valid=1 SHALL be exactly 1 cycle; from an EMIT handshake to the next rd_req=1 SHALL be exactly 1 cycle.
REQ-019 start asserted while busy=1 SHALL be ignored.
REQ-020 rd_ack while rd_req=0, and step_ready while step_valid=0, SHALL be ignored.
REQ-021 Outputs other than step_* SHALL be registered; step_* SHALL come directly from registers.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state to IDLE and force busy, rd_req, step_valid, step_last, done and err to 0.
REQ-023 rst_n=0 SHALL asynchronously clear the coordinates, the step counter and every step_*/rd_* data output to 0.
REQ-024 A reset during a walk SHALL abandon the walk with no done pulse.

Configuration
REQ-025 With PATH_WALKER_STEP_LIMIT_EN defined, an EMIT handshake with step_last=0 when the step count equals MAX_STEPS-1 SHALL go to FIN with err=1.
REQ-026 With PATH_WALKER_STEP_LIMIT_EN undefined, the step counter SHALL be absent and a walk SHALL end only by source, bounds or unreached cost.

Structure
REQ-027 Package dkstr_pkg SHALL hold the direction codes (DIR_NONE, DIR_N … DIR_NW), the cost width, the COST_INF definition and the FSM state encoding.
REQ-028 Sub-module dir_step SHALL be combinational: inputs x, y and dir; outputs nx, ny and oob.

Verification
REQ-029 Straight walk: start (3,0); grid dirs (3,0)=1_100, (3,1)=1_100, (3,2)=0_000; step_ready=1 -> steps (3,0),(3,1),(3,2); last only on (3,2); done=1, err=0.
REQ-030 Diagonal walk: start (2,2) dir=1_111 (NW), (1,1)=1_111, (0,0)=0_000 -> steps (2,2),(1,1),(0,0); then done with err=0.
REQ-031 Unreached node: start at a node with rd_cost=0xFFF -> no step_valid; done=1, err=1.
REQ-032 Out of bounds and backpressure: start (0,5) dir=1_110 (W) -> one step at (0,5), then err=1; with step_ready low for 4 cycles, step_* SHALL stay stable and rd_req SHALL stay 0.
REQ-033 Step limit, macro defined, MAX_STEPS=4: a 2-node cycle (1,1) E <-> (2,1) W -> exactly 4 steps, then err=1.
REQ-034 Reset mid-walk: rst_n=0 in READ with rd_ack pending -> all outputs 0 in the same cycle; a new start SHALL then complete normally.
